// File: rtl/baud_cfg_pkg.sv
// Shared types and constants for the baud-rate change sequencer.
// Optional drain timeout is enabled with the BAUD_DRAIN_TIMEOUT_EN macro.
package baud_cfg_pkg;

  localparam int BAUD_SEL_W = 2;

  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_4800   = 2'b00;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_9600   = 2'b01;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_115200 = 2'b10;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_AUX    = 2'b11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    APPLY,
    SETTLE,
    DONE,
    ERR
  } cfg_state_t;

  // Counter width large enough to hold the larger of the two interval lengths.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/baud_cfg_controller_counter.sv
// Loadable, saturating down-counter with a zero flag.
// Shared by the SETTLE interval and the optional drain timeout
// (BAUD_DRAIN_TIMEOUT_EN).
module cfg_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load wins over decrement; the count stops at zero instead of wrapping.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/baud_cfg_controller.sv
// Baud-rate change sequencer: drains the UART, pulses the divider reset,
// applies the new select, waits a settle interval, then acknowledges.
// Also runs the power-up apply/settle pass after reset.
// Optional feature macro: BAUD_DRAIN_TIMEOUT_EN (aborts a drain that
// exceeds DRAIN_TIMEOUT cycles with a cfg_err pulse).
module baud_cfg_controller
  import baud_cfg_pkg::*;
#(
  parameter int                    SETTLE_CYCLES = 16,
  parameter logic [BAUD_SEL_W-1:0] DEFAULT_SEL   = BAUD_SEL_9600,
  parameter int                    DRAIN_TIMEOUT = 1_000_000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  cfg_req,
  input  logic [BAUD_SEL_W-1:0] cfg_sel,
  output logic                  cfg_busy,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  input  logic                  tx_busy,
  input  logic                  rx_busy,
  output logic                  tx_hold,
  output logic                  rx_hold,
  output logic                  div_rst,
  output logic [BAUD_SEL_W-1:0] baud_sel,
  output logic                  link_ready
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef BAUD_DRAIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);
  logic err_reg;
`endif

  cfg_state_t            state_reg;
  cfg_state_t            state_next;
  logic [BAUD_SEL_W-1:0] pending_sel_reg;
  logic                  powerup_reg;
  logic                  drain_clear;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_load_value;
  logic                  cnt_enable;
  logic                  cnt_zero;

  assign drain_clear = !tx_busy && !rx_busy;

  // Next-state selection; the counter zero flag ends SETTLE (and DRAIN on timeout).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:   state_next = APPLY;
      IDLE: begin
        if (cfg_req) begin
          state_next = (cfg_sel == baud_sel) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_clear) begin
          state_next = APPLY;
        end
`ifdef BAUD_DRAIN_TIMEOUT_EN
        else if (cnt_zero) begin
          state_next = ERR;
        end
`endif
      end
      APPLY:  state_next = SETTLE;
      SETTLE: begin
        if (cnt_zero) begin
          state_next = powerup_reg ? IDLE : DONE;
        end
      end
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Counter is loaded on entry to SETTLE (and DRAIN when the timeout is built in).
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = SETTLE_LOAD;
    cnt_enable     = (state_reg == SETTLE);
    if ((state_next == SETTLE) && (state_reg != SETTLE)) begin
      cnt_load = 1'b1;
    end
`ifdef BAUD_DRAIN_TIMEOUT_EN
    else if ((state_next == DRAIN) && (state_reg != DRAIN)) begin
      cnt_load       = 1'b1;
      cnt_load_value = DRAIN_LOAD;
    end
    if (state_reg == DRAIN) begin
      cnt_enable = 1'b1;
    end
`endif
  end

  cfg_cycle_counter #(
    .WIDTH(CNT_W)
  ) u_counter (
    .clk_in    (clk_in),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .enable    (cnt_enable),
    .zero      (cnt_zero)
  );

  // State register plus Moore outputs registered from the upcoming state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg  <= INIT;
      tx_hold    <= 1'b1;
      rx_hold    <= 1'b1;
      cfg_busy   <= 1'b1;
      div_rst    <= 1'b0;
      link_ready <= 1'b0;
      cfg_ack    <= 1'b0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tx_hold    <= 1'b1;
      rx_hold    <= 1'b1;
      cfg_busy   <= 1'b1;
      div_rst    <= 1'b0;
      link_ready <= 1'b0;
      cfg_ack    <= 1'b0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
      err_reg    <= (state_next == ERR);
`endif
      case (state_next)
        IDLE: begin
          tx_hold    <= 1'b0;
          rx_hold    <= 1'b0;
          cfg_busy   <= 1'b0;
          link_ready <= 1'b1;
        end
        DRAIN: begin
          link_ready <= 1'b1;
        end
        APPLY: begin
          div_rst <= 1'b1;
        end
        DONE: begin
          tx_hold    <= 1'b0;
          rx_hold    <= 1'b0;
          link_ready <= 1'b1;
          cfg_ack    <= 1'b1;
        end
        ERR: begin
          tx_hold    <= 1'b0;
          rx_hold    <= 1'b0;
          link_ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Select register, captured request and the power-up pass flag.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      baud_sel        <= DEFAULT_SEL;
      pending_sel_reg <= DEFAULT_SEL;
      powerup_reg     <= 1'b1;
    end else begin
      if ((state_reg == IDLE) && cfg_req && (cfg_sel != baud_sel)) begin
        pending_sel_reg <= cfg_sel;
      end
      if (state_reg == APPLY) begin
        baud_sel <= pending_sel_reg;
      end
      if ((state_reg == SETTLE) && cnt_zero) begin
        powerup_reg <= 1'b0;
      end
    end
  end

`ifdef BAUD_DRAIN_TIMEOUT_EN
  assign cfg_err = err_reg;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_baud_cfg_controller.sv
// Self-checking bench for baud_cfg_controller: directed and randomized
// baud changes checked against timing rules computed from arithmetic.
// Covers the BAUD_DRAIN_TIMEOUT_EN build as well when that macro is defined.
module tb_baud_cfg_controller;

  localparam int S  = 4;
  localparam int DT = 8;
`ifdef BAUD_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       cfg_busy, cfg_ack, cfg_err, tx_hold, rx_hold, div_rst, link_ready;
  logic [1:0] baud_sel;

  int errors = 0;
  int checks = 0;
  logic [1:0] model_baud;

  baud_cfg_controller #(
    .SETTLE_CYCLES(S),
    .DEFAULT_SEL  (2'b01),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_req   (cfg_req),
    .cfg_sel   (cfg_sel),
    .cfg_busy  (cfg_busy),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err),
    .tx_busy   (tx_busy),
    .rx_busy   (rx_busy),
    .tx_hold   (tx_hold),
    .rx_hold   (rx_hold),
    .div_rst   (div_rst),
    .baud_sel  (baud_sel),
    .link_ready(link_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One requested change. Expected timing from the rules:
  //   same select      -> ack one cycle after acceptance
  //   otherwise        -> first drain cycle with both busy low is d = max(1,b),
  //                       divider reset at d+1, ack at d+2+S
  //   timeout build    -> busy still high for all DT drain cycles (b > DT)
  //                       gives err at DT+1 and no change
  task automatic do_change(input logic [1:0] sel, input int b, input bit use_rx, input bit extra);
    logic [1:0] old;
    bit   same, timeout;
    int   d, exp_div_k, exp_end;
    int   ack_cnt = 0, ack_k = -1, div_cnt = 0, div_k = -1, err_cnt = 0, err_k = -1;
    bit   drain_bad = 0, same_bad = 0;
    logic busy_after = 1'b1;
    logic hold_at_end = 1'b1;
    logic [1:0] sel_seen = 2'bxx;

    old     = model_baud;
    same    = (sel == old);
    timeout = TO_EN && !same && (b > DT);
    d       = (b > 1) ? b : 1;
    if (same) begin
      exp_div_k = -1;
      exp_end   = 1;
    end else if (timeout) begin
      exp_div_k = -1;
      exp_end   = DT + 1;
    end else begin
      exp_div_k = d + 1;
      exp_end   = d + 2 + S;
    end

    cfg_sel = sel;
    cfg_req = 1'b1;
    if (b > 0) begin
      if (use_rx) rx_busy = 1'b1;
      else tx_busy = 1'b1;
    end

    for (int k = 1; k <= exp_end + 2; k++) begin
      tick();
      if (cfg_ack) begin ack_cnt++; if (ack_k < 0) ack_k = k; end
      if (div_rst) begin div_cnt++; if (div_k < 0) div_k = k; end
      if (cfg_err) begin err_cnt++; if (err_k < 0) err_k = k; end
      if (!same && (k < (timeout ? exp_end : exp_div_k)) &&
          (tx_hold !== 1'b1 || rx_hold !== 1'b1 || baud_sel !== old || link_ready !== 1'b1))
        drain_bad = 1;
      if (same && (tx_hold !== 1'b0 || rx_hold !== 1'b0 || link_ready !== 1'b1))
        same_bad = 1;
      if (!same && !timeout && k == exp_div_k + 1) sel_seen = baud_sel;
      if (k == exp_end) hold_at_end = tx_hold | rx_hold;
      if (k == exp_end + 1) busy_after = cfg_busy;
      // Inputs for the next cycle
      if (k == 1) begin
        cfg_req = 1'b0;
        cfg_sel = 2'($urandom_range(0, 3));
      end
      if (extra && k == 3) begin
        cfg_req = 1'b1;
        cfg_sel = ~sel;
      end
      if (extra && k == 4) cfg_req = 1'b0;
      if (k == b) begin
        tx_busy = 1'b0;
        rx_busy = 1'b0;
      end
    end
    tx_busy = 1'b0;
    rx_busy = 1'b0;

    chk("ack_count", ack_cnt, timeout ? 0 : 1);
    chk("err_count", err_cnt, timeout ? 1 : 0);
    chk("div_rst_count", div_cnt, (same || timeout) ? 0 : 1);
    chk("baud_sel_final", baud_sel, timeout ? old : sel);
    chk("busy_after_end", busy_after, 0);
    chk("holds_released_at_end", hold_at_end, 0);
    if (same) begin
      chk("same_ack_cycle", ack_k, 1);
      chk("same_undisturbed", same_bad, 0);
    end else if (timeout) begin
      chk("err_cycle", err_k, DT + 1);
      chk("drain_holds", drain_bad, 0);
    end else begin
      chk("ack_cycle", ack_k, exp_end);
      chk("div_rst_cycle", div_k, exp_div_k);
      chk("sel_after_apply", sel_seen, sel);
      chk("drain_holds", drain_bad, 0);
    end
    if (!timeout) model_baud = sel;
    $display("txn sel=%0d old=%0d busy_len=%0d rx=%0d extra=%0d ack_k=%0d err_k=%0d baud=%0d",
             sel, old, b, use_rx, extra, ack_k, err_k, baud_sel);
  endtask

  initial begin
    int acks;
    model_baud = 2'b01;

    // Asynchronous reset values, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_baud_sel", baud_sel, 2'b01);
    chk("rst_tx_hold", tx_hold, 1);
    chk("rst_rx_hold", rx_hold, 1);
    chk("rst_cfg_busy", cfg_busy, 1);
    chk("rst_div_rst", div_rst, 0);
    chk("rst_link_ready", link_ready, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_cfg_err", cfg_err, 0);
    tick();
    tick();
    reset = 1'b0;

    // Power-up pass: INIT, APPLY, S x SETTLE, then IDLE with no ack
    acks = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (cfg_ack) acks++;
      chk("pu_div_rst", div_rst, (k == 1) ? 1 : 0);
      chk("pu_baud_sel", baud_sel, 2'b01);
      chk("pu_link_ready", link_ready, (k >= S + 2) ? 1 : 0);
      chk("pu_tx_hold", tx_hold, (k >= S + 2) ? 0 : 1);
    end
    chk("pu_no_ack", acks, 0);
    $display("txn powerup baud=%0d link_ready=%0d", baud_sel, link_ready);

    // Directed changes
    do_change(2'b10, 0, 0, 0);   // idle UART: div_rst t+2, ack t+7
    do_change(2'b11, 20, 0, 0);  // long tx drain (timeout build: aborts)
    do_change(model_baud, 0, 0, 0); // same select: immediate ack
    do_change(~model_baud, 3, 1, 1); // second request while busy is ignored
    do_change(model_baud ^ 2'b01, DT, 1, 0);     // busy falls on the timeout cycle
    do_change(model_baud ^ 2'b10, DT + 1, 1, 0); // busy one cycle past the timeout
    do_change(model_baud ^ 2'b11, 30, 1, 0);     // rx stuck high

    // Randomized changes
    for (int n = 0; n < 14; n++) begin
      do_change(2'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of SETTLE loses the request
    if (model_baud == 2'b01) do_change(2'b10, 0, 0, 0);
    cfg_sel = ~model_baud;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_baud_sel", baud_sel, 2'b01);
    chk("midrst_cfg_busy", cfg_busy, 1);
    chk("midrst_link_ready", link_ready, 0);
    chk("midrst_tx_hold", tx_hold, 1);
    chk("midrst_div_rst", div_rst, 0);
    tick();
    reset = 1'b0;
    acks = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cfg_ack || cfg_err) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    chk("midrst_baud_after", baud_sel, 2'b01);
    chk("midrst_link_after", link_ready, 1);
    model_baud = 2'b01;
    $display("txn midsettle_reset baud=%0d", baud_sel);

    do_change(2'b00, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baud_cfg_controller.md
Name: baud_cfg_controller

Overview:
- Sequences run-time baud-rate changes for the UART baud generators (transmitter and receiver selectors plus their clock dividers).
- Accepts a select request, holds off TX/RX until both are idle, resets the dividers, drives the new 2-bit select, waits a settle interval, then releases the link and acknowledges.
- Also performs the power-up sequence after reset.

Parameters:
- SETTLE_CYCLES, 16: clk_in cycles spent in SETTLE after divider reset; must be >= 1.
- DEFAULT_SEL, 2'b01: baud select applied at reset (9600).
- DRAIN_TIMEOUT, 1_000_000: maximum DRAIN cycles before abort (only with the optional feature).

Ports:
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_req  in  1  request a baud change; sampled only in IDLE
- cfg_sel  in  2  requested select; captured when cfg_req is accepted
- cfg_busy  out  1  high in every state except IDLE
- cfg_ack  out  1  one-cycle pulse: change complete
- cfg_err  out  1  one-cycle pulse: request aborted (optional feature only; otherwise tied 0)
- tx_busy  in  1  transmitter mid-frame
- rx_busy  in  1  receiver mid-frame
- tx_hold  out  1  transmitter must not start a new frame
- rx_hold  out  1  receiver must ignore start bits
- div_rst  out  1  synchronous reset to all baud clock dividers
- baud_sel  out  2  drives S of the transmitter and receiver baud selectors
- link_ready  out  1  baud clock valid and stable

Behaviour:
- Moore FSM. All outputs are registered or decoded from the state register; baud_sel is its own register.
- States: INIT, IDLE, DRAIN, APPLY, SETTLE, DONE, ERR.
- Reset values (asynchronous, while reset=1):
  - state = INIT, baud_sel = DEFAULT_SEL
  - tx_hold = rx_hold = 1, cfg_busy = 1
  - div_rst = 0, link_ready = 0, cfg_ack = 0, cfg_err = 0
- INIT: one cycle, then APPLY. The power-up pass goes APPLY -> SETTLE -> IDLE and produces no cfg_ack.
- IDLE: tx_hold = rx_hold = 0, link_ready = 1, cfg_busy = 0.
  - cfg_req = 1 and cfg_sel == baud_sel: go to DONE (ack at t+1, no divider disturbance).
  - cfg_req = 1 and cfg_sel != baud_sel: latch cfg_sel into pending_sel, go to DRAIN.
- DRAIN: tx_hold = rx_hold = 1, link_ready = 1. When tx_busy == 0 and rx_busy == 0 in the same cycle, go to APPLY.
- APPLY: exactly one cycle. div_rst = 1, link_ready = 0, baud_sel <= pending_sel (visible in the next cycle). Go to SETTLE.
- SETTLE: div_rst = 0, link_ready = 0, holds stay 1. The counter loads SETTLE_CYCLES-1 on entry and counts down; at 0, go to DONE (or to IDLE on the power-up pass).
- DONE: one cycle. cfg_ack = 1, link_ready = 1, holds released. Go to IDLE.
- Latency with an idle UART, request accepted at cycle t:
  - DRAIN at t+1, APPLY at t+2, SETTLE from t+3 to t+2+SETTLE_CYCLES
  - cfg_ack at t+3+SETTLE_CYCLES
- cfg_req outside IDLE is ignored and not queued. The requester waits for cfg_busy = 0 and re-asserts.
- cfg_sel changes after acceptance have no effect.
- tx_busy/rx_busy toggling during SETTLE is ignored; the holds guarantee no new frames.
- Reset asserted mid-sequence: immediate return to reset values. The pending request is lost, with no ack and no err.
- Counter width is $clog2(max(SETTLE_CYCLES, DRAIN_TIMEOUT)+1). No wrap: the counter saturates at 0.

Optional Feature:
- BAUD_DRAIN_TIMEOUT_EN defined:
  - DRAIN counts cycles from entry.
  - If DRAIN_TIMEOUT cycles elapse without both busy inputs low, go to ERR.
  - ERR is one cycle: cfg_err = 1, holds released, baud_sel unchanged. Then IDLE.
  - If the busy inputs go low on the same cycle the timeout expires, the drain succeeds and the FSM goes to APPLY.
- Not defined: DRAIN waits indefinitely, there is no ERR state, and cfg_err is tied 0.

Decomposition:
- Package baud_cfg_pkg holds:
  - state enum cfg_state_t
  - select constants BAUD_SEL_4800 = 2'b00, BAUD_SEL_9600 = 2'b01, BAUD_SEL_115200 = 2'b10, BAUD_SEL_AUX = 2'b11
  - BAUD_SEL_W = 2
- One sub-module, cfg_cycle_counter: a loadable, saturating down-counter with load, enable and zero flag. It is shared by SETTLE and the DRAIN timeout.

Test Plan:
- Reset release, SETTLE_CYCLES = 4 -> baud_sel = 01 throughout; div_rst pulses 1 cycle after INIT; link_ready = 1 and holds = 0 six cycles after reset deasserts; no cfg_ack.
- Idle UART, cfg_req with cfg_sel = 10 at t -> div_rst at t+2, baud_sel = 10 at t+3, cfg_ack single pulse at t+7, cfg_busy low at t+8.
- tx_busy high for 20 cycles after request -> FSM stays in DRAIN with tx_hold = rx_hold = 1 and baud_sel unchanged; APPLY occurs the cycle after tx_busy falls.
- cfg_req with cfg_sel equal to the current baud_sel -> cfg_ack at t+1; div_rst, holds and link_ready undisturbed.
- Second cfg_req while cfg_busy = 1 -> ignored; exactly one ack; baud_sel reflects the first request only. Reset asserted during SETTLE -> baud_sel returns to 01 and no ack.
- With BAUD_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT = 8, rx_busy held high -> cfg_err pulse 9 cycles after acceptance; baud_sel unchanged; holds released.
